seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_pkg.sv | 23 ++
 rtl/sat_counter.sv | 25 ++
 rtl/seq_detect_param.sv | 136 +++++++++++++
 tb/tb_seq_detect_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_e     : control FSM encoding (also driven out on state_o)
//   PAT_W_*     : legal pattern length range
//   CNT_W_*     : legal match counter width range
//   fill_width  : bits needed to count 0..pat_w-1 valid history bits
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for the match count.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   inc          : count up by one, holding at all-ones
//   clr          : synchronous clear, wins over inc
//   count        : current value
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a loadable pattern, overlapping or
// non-overlapping matching and a saturating match counter.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   x, enable    : serial data bit, consumed only while enable=1
//   load, pat_in : replace the pattern (accepted in IDLE only); pat_in MSB
//                  is the first bit of the sequence
//   overlap      : 1 = a match keeps its tail as history for the next one
//   z            : Mealy match flag, same cycle as the final bit
//   match_cnt    : saturating count of z pulses
//   state_o      : control state for debug
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int              PAT_W   = 4,
    parameter int              CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1001)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
    input  logic             enable,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state_o
);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
        $error("seq_detect_param: PAT_W or CNT_W out of range");
    end

    localparam int               FILL_W   = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [PAT_W-2:0]   hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;

    logic [PAT_W-1:0]   window;
    logic [PAT_W-2:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               hit;
    logic               load_acc;

    // Candidate sequence: stored history plus the bit arriving now. Slicing
    // the window (rather than hist itself) keeps PAT_W=2 legal.
    assign window     = {hist_q, x};
    assign hist_shift = window[PAT_W-2:0];
    assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pat_q   <= RST_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        hit      = 1'b0;
        load_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Load beats enable: the data bit of this cycle is dropped.
                if (load) begin
                    load_acc = 1'b1;
                    pat_d    = pat_in;
                    hist_d   = '0;
                    fill_d   = '0;
                end else if (enable) begin
                    // Resume where the paused stream left off.
                    hist_d  = hist_shift;
                    fill_d  = fill_inc;
                    state_d = (fill_inc == FILL_MAX) ? ST_RUN : ST_FILL;
                end
            end
            ST_FILL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    if (fill_inc == FILL_MAX)
                        state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (window == pat_q) begin
                    hit = 1'b1;
                    if (overlap) begin
                        hist_d = hist_shift;
                        fill_d = fill_inc;
                    end else begin
                        // Non-overlapping: the next match needs PAT_W new bits.
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = ST_FILL;
                    end
                end else begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // hit already implies enable and RUN; reset gates it combinationally.
    assign z       = hit & reset;
    assign state_o = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (z),
        .clr   (load_acc),
        .count (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // A: defaults (PAT_W=4, CNT_W=8)
    logic       a_rst, a_x, a_en, a_ld, a_ov, a_z;
    logic [3:0] a_pi;
    logic [7:0] a_cnt;
    logic [1:0] a_st;
    // B: PAT_W=8
    logic       b_rst, b_x, b_en, b_ld, b_ov, b_z;
    logic [7:0] b_pi, b_cnt;
    logic [1:0] b_st;
    // C: CNT_W=2
    logic       c_rst, c_x, c_en, c_ld, c_ov, c_z;
    logic [3:0] c_pi;
    logic [1:0] c_cnt, c_st;

    seq_detect_param u_dut_a (
        .clock(clock), .reset(a_rst), .x(a_x), .enable(a_en), .load(a_ld),
        .pat_in(a_pi), .overlap(a_ov), .z(a_z), .match_cnt(a_cnt), .state_o(a_st));

    seq_detect_param #(.PAT_W(8)) u_dut_b (
        .clock(clock), .reset(b_rst), .x(b_x), .enable(b_en), .load(b_ld),
        .pat_in(b_pi), .overlap(b_ov), .z(b_z), .match_cnt(b_cnt), .state_o(b_st));

    seq_detect_param #(.CNT_W(2)) u_dut_c (
        .clock(clock), .reset(c_rst), .x(c_x), .enable(c_en), .load(c_ld),
        .pat_in(c_pi), .overlap(c_ov), .z(c_z), .match_cnt(c_cnt), .state_o(c_st));

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    task automatic reset_a();
        @(negedge clock); a_rst = 1'b0; a_en = 1'b0; a_ld = 1'b0;
        @(negedge clock); a_rst = 1'b1;
    endtask

    task automatic test_reset();
        bit ez;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); a_rst = 1'b0; a_en = 1'b1; a_x = 1'b1;
            exp_q.push_back(1'b0);
            #2; ez = exp_q.pop_front(); checks++;
            if (a_z !== ez) begin errors++; $display("FAIL reset_z got %b want %b", a_z, ez); end
        end
        @(negedge clock); a_en = 1'b0;
        checks++;
        if (a_st !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", a_st); end
        checks++;
        if (a_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", a_cnt); end
        a_rst = 1'b1;
    endtask

    task automatic test_stream(input bit ov, input logic [6:0] e, input logic [7:0] want_cnt);
        logic [6:0] s = 7'b1001001;
        bit ez;
        reset_a();
        for (int i = 6; i >= 0; i--) begin
            @(negedge clock); a_en = 1'b1; a_x = s[i]; a_ov = ov; a_ld = 1'b0;
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (a_z !== ez) begin errors++; $display("FAIL stream_ov%0d_z bit%0d got %b want %b", ov, 7 - i, a_z, ez); end
        end
        @(negedge clock); a_en = 1'b0;
        checks++;
        if (a_cnt !== want_cnt) begin errors++; $display("FAIL stream_ov%0d_cnt got %0d want %0d", ov, a_cnt, want_cnt); end
    endtask

    task automatic test_load_ignored();
        logic [6:0] s  = 7'b1001001;
        logic [6:0] ld = 7'b0001111;
        logic [6:0] e  = 7'b0001001;
        bit ez;
        reset_a();
        for (int i = 6; i >= 0; i--) begin
            @(negedge clock); a_en = 1'b1; a_x = s[i]; a_ov = 1'b1; a_ld = ld[i]; a_pi = 4'b0000;
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (a_z !== ez) begin errors++; $display("FAIL load_run_z bit%0d got %b want %b", 7 - i, a_z, ez); end
        end
        @(negedge clock); a_ld = 1'b0;
        checks++;
        if (a_cnt !== 8'd2) begin errors++; $display("FAIL load_run_cnt got %0d want 2", a_cnt); end
    endtask

    // Continues from RUN left by test_load_ignored.
    task automatic test_load_idle();
        logic [3:0] s = 4'b0110;
        logic [3:0] e = 4'b0001;
        bit ez;
        @(negedge clock); a_en = 1'b0; a_ld = 1'b0; a_x = 1'b1;
        @(negedge clock); a_en = 1'b1; a_ld = 1'b1; a_x = 1'b1; a_pi = 4'b0110;
        exp_q.push_back(1'b0);
        #2; ez = exp_q.pop_front(); checks++;
        if (a_z !== ez) begin errors++; $display("FAIL load_idle_z got %b want %b", a_z, ez); end
        @(negedge clock); a_en = 1'b0; a_ld = 1'b0;
        checks++;
        if (a_st !== 2'b00) begin errors++; $display("FAIL load_idle_state got %b want 00", a_st); end
        checks++;
        if (a_cnt !== 8'd0) begin errors++; $display("FAIL load_idle_cnt got %0d want 0", a_cnt); end
        for (int i = 3; i >= 0; i--) begin
            @(negedge clock); a_en = 1'b1; a_x = s[i]; a_ov = 1'b1;
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (a_z !== ez) begin errors++; $display("FAIL new_pat_z bit%0d got %b want %b", 4 - i, a_z, ez); end
        end
        @(negedge clock); a_en = 1'b0;
        checks++;
        if (a_cnt !== 8'd1) begin errors++; $display("FAIL new_pat_cnt got %0d want 1", a_cnt); end
    endtask

    task automatic test_pause();
        logic [5:0] s  = 6'b101101;
        logic [5:0] en = 6'b110011;
        logic [5:0] e  = 6'b000001;
        bit ez;
        reset_a();
        for (int i = 5; i >= 0; i--) begin
            @(negedge clock); a_en = en[i]; a_x = s[i]; a_ov = 1'b1; a_ld = 1'b0;
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (a_z !== ez) begin errors++; $display("FAIL pause_z step%0d got %b want %b", 6 - i, a_z, ez); end
            if (i == 2) begin
                checks++;
                if (a_st !== 2'b00) begin errors++; $display("FAIL pause_state got %b want 00", a_st); end
            end
        end
    endtask

    // Starts from RUN with history 001 and one match counted.
    task automatic test_mid_reset();
        logic [7:0] s  = 8'b10011001;
        logic [7:0] rs = 8'b11101111;
        logic [7:0] e  = 8'b00000001;
        bit ez;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clock); a_rst = rs[i]; a_en = 1'b1; a_x = s[i]; a_ov = 1'b1; a_ld = 1'b0;
            if (i == 3) begin
                checks++;
                if (a_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d want 0", a_cnt); end
            end
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (a_z !== ez) begin errors++; $display("FAIL mid_reset_z bit%0d got %b want %b", 8 - i, a_z, ez); end
        end
        @(negedge clock); a_en = 1'b0;
        checks++;
        if (a_cnt !== 8'd1) begin errors++; $display("FAIL mid_reset_final_cnt got %0d want 1", a_cnt); end
    endtask

    task automatic test_pat8();
        logic [15:0] s = 16'hA5A5;
        logic [15:0] e = 16'b0000_0001_0000_0001;
        bit ez;
        @(negedge clock); b_rst = 1'b0; b_en = 1'b0; b_ld = 1'b0;
        @(negedge clock); b_rst = 1'b1; b_ld = 1'b1; b_pi = 8'hA5;
        @(negedge clock); b_ld = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clock); b_en = 1'b1; b_x = s[i]; b_ov = 1'b0;
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (b_z !== ez) begin errors++; $display("FAIL pat8_z bit%0d got %b want %b", 16 - i, b_z, ez); end
        end
        @(negedge clock); b_en = 1'b0;
        checks++;
        if (b_cnt !== 8'd2) begin errors++; $display("FAIL pat8_cnt got %0d want 2", b_cnt); end
    endtask

    task automatic test_saturate();
        logic [15:0] s = 16'b1001_0010_0100_1001;
        logic [15:0] e = 16'b0001_0010_0100_1001;
        logic [1:0]  want = 2'd0;
        bit ez;
        @(negedge clock); c_rst = 1'b0; c_en = 1'b0; c_ld = 1'b0;
        @(negedge clock); c_rst = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clock);
            checks++;
            if (c_cnt !== want) begin errors++; $display("FAIL sat_cnt before bit%0d got %0d want %0d", 16 - i, c_cnt, want); end
            c_en = 1'b1; c_x = s[i]; c_ov = 1'b1;
            exp_q.push_back(e[i]);
            #2; ez = exp_q.pop_front(); checks++;
            if (c_z !== ez) begin errors++; $display("FAIL sat_z bit%0d got %b want %b", 16 - i, c_z, ez); end
            if (ez && want != 2'd3) want = want + 2'd1;
        end
        @(negedge clock); c_en = 1'b0;
        checks++;
        if (c_cnt !== 2'd3) begin errors++; $display("FAIL sat_final_cnt got %0d want 3", c_cnt); end
    endtask

    initial begin
        a_rst = 1'b0; a_x = 1'b0; a_en = 1'b0; a_ld = 1'b0; a_ov = 1'b1; a_pi = 4'd0;
        b_rst = 1'b0; b_x = 1'b0; b_en = 1'b0; b_ld = 1'b0; b_ov = 1'b0; b_pi = 8'd0;
        c_rst = 1'b0; c_x = 1'b0; c_en = 1'b0; c_ld = 1'b0; c_ov = 1'b1; c_pi = 4'd0;
        test_reset();
        test_stream(1'b1, 7'b0001001, 8'd2);
        test_stream(1'b0, 7'b0001000, 8'd1);
        test_load_ignored();
        test_load_idle();
        test_pause();
        test_mid_reset();
        test_pat8();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
